// File: rtl/icache_refill_responder.sv
// ICache line refill engine: accepts a miss, fetches the line word by word from
// memory, assembles it and returns it with the victim way; supports flush/drain.

package config_pkg;
    typedef struct packed {
        int unsigned xlen;
        int unsigned plen;
        int unsigned icache_line_width;
        int unsigned icache_set_assoc;
    } user_cfg_t;

    typedef struct packed {
        int unsigned PLEN;
        int unsigned XLEN;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned ICACHE_OFFSET_WIDTH;
        int unsigned ICACHE_SET_ASSOC_WIDTH;
    } cfg_t;

    localparam user_cfg_t user_cfg_default = '{
        xlen:              32'd32,
        plen:              32'd32,
        icache_line_width: 32'd256,
        icache_set_assoc:  32'd4
    };
endpackage

package build_config_pkg;
    function automatic config_pkg::cfg_t build_config(input config_pkg::user_cfg_t user_cfg);
        config_pkg::cfg_t cfg;
        cfg.PLEN                = user_cfg.plen;
        cfg.XLEN                = user_cfg.xlen;
        cfg.ICACHE_LINE_WIDTH   = user_cfg.icache_line_width;
        cfg.ICACHE_OFFSET_WIDTH = 32'($clog2(user_cfg.icache_line_width / 32'd8));
        if (user_cfg.icache_set_assoc > 32'd1) begin
            cfg.ICACHE_SET_ASSOC_WIDTH = 32'($clog2(user_cfg.icache_set_assoc));
        end else begin
            cfg.ICACHE_SET_ASSOC_WIDTH = 32'd1;
        end
        return cfg;
    endfunction
endpackage

module icache_refill_responder_chk #(
    parameter int NBEATS = 8,
    parameter int CNT_W  = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             mem_rsp_valid_i,
    input logic [CNT_W-1:0] outstanding_i
);
    if ((NBEATS < 2) || ((NBEATS & (NBEATS - 1)) != 0)) begin : g_nbeats_bad
        $error("icache_refill_responder: NBEATS must be a power of two and at least 2");
    end

    // A memory beat with nothing outstanding is a protocol violation by the memory side.
    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem_rsp_valid_i && (outstanding_i == '0)));
endmodule

module icache_refill_responder #(
    parameter config_pkg::cfg_t Cfg = build_config_pkg::build_config(config_pkg::user_cfg_default),
    localparam int PLEN       = int'(Cfg.PLEN),
    localparam int XLEN       = int'(Cfg.XLEN),
    localparam int LINE_W     = int'(Cfg.ICACHE_LINE_WIDTH),
    localparam int OFFSET_W   = int'(Cfg.ICACHE_OFFSET_WIDTH),
    localparam int WAY_W      = int'(Cfg.ICACHE_SET_ASSOC_WIDTH),
    localparam int NBEATS     = LINE_W / XLEN,
    localparam int IDX_W      = $clog2(NBEATS),
    localparam int CNT_W      = IDX_W + 1,
    localparam int WORD_SHIFT = $clog2(XLEN / 8)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              refill_req_valid_i,
    output logic              refill_req_ready_o,
    input  logic [PLEN-1:0]   refill_req_addr_i,
    input  logic [WAY_W-1:0]  refill_req_way_i,
    output logic              refill_rsp_valid_o,
    input  logic              refill_rsp_ready_i,
    output logic [LINE_W-1:0] refill_rsp_data_o,
    output logic [PLEN-1:0]   refill_rsp_addr_o,
    output logic [WAY_W-1:0]  refill_rsp_way_o,
    output logic              refill_rsp_err_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [PLEN-1:0]   mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [XLEN-1:0]   mem_rsp_data_i,
    input  logic              mem_rsp_err_i,
    input  logic              flush_i
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e              state_r;
    state_e              state_next_s;
    logic [CNT_W-1:0]    issue_cnt_r;
    logic [CNT_W-1:0]    rcv_cnt_r;
    logic [PLEN-1:0]     base_r;
    logic [WAY_W-1:0]    way_r;
    logic                err_r;
    logic [LINE_W-1:0]   line_r;

    logic [CNT_W-1:0]    outstanding_s;
    logic [CNT_W-1:0]    outstanding_after_s;
    logic [IDX_W-1:0]    rcv_idx_s;
    logic                req_fire_s;
    logic                issue_fire_s;
    logic                rsp_take_s;

    assign outstanding_s       = issue_cnt_r - rcv_cnt_r;
    assign rcv_idx_s           = rcv_cnt_r[IDX_W-1:0];
    // Beats only count while a refill is in flight, and never past what was issued.
    assign rsp_take_s          = mem_rsp_valid_i && (outstanding_s != '0)
                                 && ((state_r == BUSY) || (state_r == DRAIN));
    assign outstanding_after_s = outstanding_s - CNT_W'(rsp_take_s);

    assign refill_req_ready_o = (state_r == IDLE) && !flush_i;
    assign req_fire_s         = refill_req_valid_i && refill_req_ready_o;
    assign mem_req_valid_o    = (state_r == BUSY) && (issue_cnt_r < CNT_W'(NBEATS)) && !flush_i;
    assign issue_fire_s       = mem_req_valid_o && mem_req_ready_i;
    assign mem_req_addr_o     = base_r + (PLEN'(issue_cnt_r) << WORD_SHIFT);

    assign refill_rsp_valid_o = (state_r == RESP);
    assign refill_rsp_data_o  = line_r;
    assign refill_rsp_addr_o  = base_r;
    assign refill_rsp_way_o   = way_r;
    assign refill_rsp_err_o   = err_r;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_fire_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    if (outstanding_after_s == '0) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end else if (rsp_take_s && (rcv_cnt_r == CNT_W'(NBEATS - 1))) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUSY;
                end
            end
            RESP: begin
                if (flush_i || refill_rsp_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            DRAIN: begin
                if (outstanding_after_s == '0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Request latch, beat counters and line assembly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_cnt_r <= '0;
            rcv_cnt_r   <= '0;
            base_r      <= '0;
            way_r       <= '0;
            err_r       <= 1'b0;
            line_r      <= '0;
        end else if (req_fire_s) begin
            issue_cnt_r <= '0;
            rcv_cnt_r   <= '0;
            base_r      <= {refill_req_addr_i[PLEN-1:OFFSET_W], {OFFSET_W{1'b0}}};
            way_r       <= refill_req_way_i;
            err_r       <= 1'b0;
        end else begin
            if (issue_fire_s) begin
                issue_cnt_r <= issue_cnt_r + CNT_W'(1);
            end
            if (rsp_take_s) begin
                rcv_cnt_r <= rcv_cnt_r + CNT_W'(1);
            end
            if (rsp_take_s && (state_r == BUSY)) begin
                err_r <= err_r | mem_rsp_err_i;
                for (int b = 0; b < NBEATS; b++) begin
                    if (rcv_idx_s == IDX_W'(b)) begin
                        line_r[b*XLEN +: XLEN] <= mem_rsp_data_i;
                    end
                end
            end
        end
    end

    icache_refill_responder_chk #(
        .NBEATS (NBEATS),
        .CNT_W  (CNT_W)
    ) u_chk (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .outstanding_i   (outstanding_s)
    );
endmodule

// File: tb/tb_icache_refill_responder.sv
// Scoreboard bench for icache_refill_responder: a small memory model answers
// word reads; expected line responses and word addresses are queued at request time.

module tb_icache_refill_responder;
    logic         clk = 1'b0;
    logic         rst_ni = 1'b1;
    logic         refill_req_valid_i = 1'b0;
    logic         refill_req_ready_o;
    logic [31:0]  refill_req_addr_i = '0;
    logic [1:0]   refill_req_way_i = '0;
    logic         refill_rsp_valid_o;
    logic         refill_rsp_ready_i = 1'b0;
    logic [255:0] refill_rsp_data_o;
    logic [31:0]  refill_rsp_addr_o;
    logic [1:0]   refill_rsp_way_o;
    logic         refill_rsp_err_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rsp_valid_i = 1'b0;
    logic [31:0]  mem_rsp_data_i = '0;
    logic         mem_rsp_err_i = 1'b0;
    logic         flush_i = 1'b0;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  addr;
        logic [1:0]   way;
        logic         err;
    } rsp_t;

    rsp_t        exp_rsp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] pend_q[$];

    int checks = 0;
    int errors = 0;
    int rsp_budget = 1000;
    int err_beat = -1;
    logic [31:0] data_base = 32'h0000_1000;

    logic s_req_ready, s_rsp_valid, s_mem_rsp_valid, s_mem_hs, s_req_fire;
    int n_mem_hs = 0;
    int n_rsp_hs = 0;
    int n_rsp_valid = 0;

    icache_refill_responder dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .refill_req_valid_i (refill_req_valid_i),
        .refill_req_ready_o (refill_req_ready_o),
        .refill_req_addr_i  (refill_req_addr_i),
        .refill_req_way_i   (refill_req_way_i),
        .refill_rsp_valid_o (refill_rsp_valid_o),
        .refill_rsp_ready_i (refill_rsp_ready_i),
        .refill_rsp_data_o  (refill_rsp_data_o),
        .refill_rsp_addr_o  (refill_rsp_addr_o),
        .refill_rsp_way_o   (refill_rsp_way_o),
        .refill_rsp_err_o   (refill_rsp_err_o),
        .mem_req_valid_o    (mem_req_valid_o),
        .mem_req_ready_i    (mem_req_ready_i),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_rsp_valid_i    (mem_rsp_valid_i),
        .mem_rsp_data_i     (mem_rsp_data_i),
        .mem_rsp_err_i      (mem_rsp_err_i),
        .flush_i            (flush_i)
    );

    initial forever #5 clk = ~clk;

    task automatic push_expect();
        rsp_t        r;
        logic [31:0] b;
        b      = refill_req_addr_i & 32'hFFFF_FFE0;
        r.data = '0;
        r.err  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_addr_q.push_back(b + 32'(k * 4));
            r.data[k*32 +: 32] = data_base + 32'(k);
            if (k == err_beat) r.err = 1'b1;
        end
        r.addr = b;
        r.way  = refill_req_way_i;
        exp_rsp_q.push_back(r);
    endtask

    // One clock: sample and score at negedge, then the memory model drives after posedge.
    task automatic tick();
        logic [31:0] ea;
        logic [31:0] a;
        rsp_t        r;
        int          beat;
        @(negedge clk);
        s_req_ready     = refill_req_ready_o;
        s_rsp_valid     = refill_rsp_valid_o;
        s_mem_rsp_valid = mem_rsp_valid_i;
        s_mem_hs        = rst_ni && mem_req_valid_o && mem_req_ready_i;
        s_req_fire      = rst_ni && refill_req_valid_i && refill_req_ready_o;
        if (s_rsp_valid) n_rsp_valid++;
        if (s_req_fire) push_expect();
        if (s_mem_hs) begin
            n_mem_hs++;
            pend_q.push_back(mem_req_addr_o);
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL mem_addr_extra got %h, none expected", mem_req_addr_o);
            end else begin
                ea = exp_addr_q.pop_front();
                if (mem_req_addr_o !== ea) begin
                    errors++;
                    $display("FAIL mem_addr got %h expected %h", mem_req_addr_o, ea);
                end
            end
        end
        if (rst_ni && s_rsp_valid && refill_rsp_ready_i && !flush_i) begin
            n_rsp_hs++;
            checks++;
            if (exp_rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_extra got addr %h, none expected", refill_rsp_addr_o);
            end else begin
                r = exp_rsp_q.pop_front();
                if (refill_rsp_data_o !== r.data || refill_rsp_addr_o !== r.addr ||
                    refill_rsp_way_o !== r.way || refill_rsp_err_o !== r.err) begin
                    errors++;
                    $display("FAIL rsp got data %h addr %h way %0d err %0b expected data %h addr %h way %0d err %0b",
                             refill_rsp_data_o, refill_rsp_addr_o, refill_rsp_way_o, refill_rsp_err_o,
                             r.data, r.addr, r.way, r.err);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst_ni && rsp_budget > 0 && pend_q.size() > 0) begin
            a               = pend_q.pop_front();
            beat            = int'((a >> 2) & 32'd7);
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = data_base + 32'(beat);
            mem_rsp_err_i   = (beat == err_beat);
            rsp_budget--;
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = '0;
            mem_rsp_err_i   = 1'b0;
        end
    endtask

    task automatic start_req(input logic [31:0] addr, input logic [1:0] way);
        bit acc = 1'b0;
        refill_req_valid_i = 1'b1;
        refill_req_addr_i  = addr;
        refill_req_way_i   = way;
        for (int i = 0; i < 20 && !acc; i++) begin
            tick();
            acc = s_req_fire;
        end
        refill_req_valid_i = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL req_accept got no acceptance within 20 cycles, required acceptance");
        end
    endtask

    task automatic wait_rsp_valid(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (s_rsp_valid) break;
        end
        checks++;
        if (!s_rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout got no refill_rsp_valid_o within 200 cycles");
        end
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #3;
        checks++;
        if (mem_req_valid_o !== 1'b0 || refill_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got mem %0b rsp %0b required 0 0", mem_req_valid_o, refill_rsp_valid_o);
        end
        checks++;
        if (refill_rsp_data_o !== '0 || refill_rsp_addr_o !== '0 || refill_rsp_way_o !== '0 ||
            refill_rsp_err_o !== 1'b0 || mem_req_addr_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr %h way %0d err %0b memaddr %h required all 0",
                     refill_rsp_addr_o, refill_rsp_way_o, refill_rsp_err_o, mem_req_addr_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (refill_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b required 1", refill_req_ready_o);
        end
    endtask

    task automatic test_nominal();
        int n;
        data_base          = 32'h0000_1000;
        err_beat           = -1;
        rsp_budget         = 1000;
        mem_req_ready_i    = 1'b1;
        refill_rsp_ready_i = 1'b1;
        start_req(32'h8000_0014, 2'd2);
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL first_issue got valid %0b addr %h required 1 80000000", mem_req_valid_o, mem_req_addr_o);
        end
        wait_rsp_valid(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL refill_latency got %0d cycles required 10", n);
        end
        checks++;
        if (s_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_resp got %0b required 0", s_req_ready);
        end
        tick();
        checks++;
        if (s_req_ready !== 1'b1 || s_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_resp got ready %0b valid %0b required 1 0", s_req_ready, s_rsp_valid);
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_rsp_q.size() != 0) begin
            errors++;
            $display("FAIL nominal_leftover got %0d addrs %0d rsps required 0 0", exp_addr_q.size(), exp_rsp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int m0;
        int h0;
        data_base          = 32'h0000_3000;
        err_beat           = -1;
        mem_req_ready_i    = 1'b1;
        refill_rsp_ready_i = 1'b0;
        m0 = n_mem_hs;
        start_req(32'h1234_5678, 2'd1);
        for (int i = 0; i < 200; i++) begin
            mem_req_ready_i = ~mem_req_ready_i;
            tick();
            if (s_rsp_valid) break;
        end
        mem_req_ready_i = 1'b1;
        checks++;
        if (!s_rsp_valid || n_mem_hs - m0 != 8 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL bp_issue got valid %0b issued %0d left %0d required 1 8 0",
                     s_rsp_valid, n_mem_hs - m0, exp_addr_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (exp_rsp_q.size() == 0 || !s_rsp_valid ||
                refill_rsp_data_o !== exp_rsp_q[0].data || refill_rsp_addr_o !== exp_rsp_q[0].addr ||
                refill_rsp_way_o !== exp_rsp_q[0].way || refill_rsp_err_o !== exp_rsp_q[0].err) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %0b addr %h way %0d required valid 1 addr 12345660 way 1",
                         i, s_rsp_valid, refill_rsp_addr_o, refill_rsp_way_o);
            end
        end
        h0 = n_rsp_hs;
        refill_rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (n_rsp_hs - h0 != 1) begin
            errors++;
            $display("FAIL bp_handshakes got %0d required 1", n_rsp_hs - h0);
        end
    endtask

    task automatic test_error();
        int n;
        data_base          = 32'h0000_2000;
        err_beat           = 3;
        mem_req_ready_i    = 1'b1;
        refill_rsp_ready_i = 1'b1;
        start_req(32'h0000_0040, 2'd3);
        wait_rsp_valid(n);
        tick();
        err_beat = -1;
        checks++;
        if (exp_rsp_q.size() != 0) begin
            errors++;
            $display("FAIL err_leftover got %0d pending responses required 0", exp_rsp_q.size());
        end
    endtask

    task automatic test_flush_busy();
        int m0;
        int m1;
        int v1;
        int drained = 0;
        data_base          = 32'h0000_4000;
        err_beat           = -1;
        rsp_budget         = 0;
        mem_req_ready_i    = 1'b1;
        refill_rsp_ready_i = 1'b1;
        m0 = n_mem_hs;
        start_req(32'h0000_1000, 2'd0);
        for (int i = 0; i < 20 && (n_mem_hs - m0) < 5; i++) tick();
        mem_req_ready_i = 1'b0;
        rsp_budget      = 2;
        for (int i = 0; i < 3; i++) tick();
        flush_i         = 1'b1;
        mem_req_ready_i = 1'b1;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b0 || n_mem_hs - m0 != 5) begin
            errors++;
            $display("FAIL flush_issue_stop got valid %0b issued %0d required 0 5", mem_req_valid_o, n_mem_hs - m0);
        end
        exp_addr_q.delete();
        exp_rsp_q.delete();
        m1 = n_mem_hs;
        v1 = n_rsp_valid;
        tick();
        flush_i    = 1'b0;
        rsp_budget = 1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_mem_rsp_valid) drained++;
            if (drained == 3) break;
        end
        checks++;
        if (drained != 3 || s_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_beats got %0d drained, ready %0b required 3 drained, ready 0", drained, s_req_ready);
        end
        checks++;
        if (refill_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_ready_return got %0b required 1", refill_req_ready_o);
        end
        tick();
        checks++;
        if (n_mem_hs != m1 || n_rsp_valid != v1 || pend_q.size() != 0) begin
            errors++;
            $display("FAIL drain_quiet got issues %0d rspvalids %0d pending %0d required 0 0 0",
                     n_mem_hs - m1, n_rsp_valid - v1, pend_q.size());
        end
    endtask

    task automatic test_flush_resp();
        int n;
        int h0;
        data_base          = 32'h0000_5000;
        mem_req_ready_i    = 1'b1;
        refill_rsp_ready_i = 1'b0;
        start_req(32'h0000_2000, 2'd1);
        wait_rsp_valid(n);
        flush_i            = 1'b1;
        refill_rsp_ready_i = 1'b1;
        h0 = n_rsp_hs;
        tick();
        checks++;
        if (n_rsp_hs != h0 || refill_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_drop got handshakes %0d valid %0b required 0 0", n_rsp_hs - h0, refill_rsp_valid_o);
        end
        exp_rsp_q.delete();
        data_base          = 32'h0000_6000;
        refill_req_valid_i = 1'b1;
        refill_req_addr_i  = 32'h0000_3004;
        refill_req_way_i   = 2'd2;
        #1;
        checks++;
        if (refill_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ready got %0b required 0", refill_req_ready_o);
        end
        tick();
        flush_i = 1'b0;
        #1;
        checks++;
        if (refill_req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_noaccept got ready %0b memvalid %0b required 1 0", refill_req_ready_o, mem_req_valid_o);
        end
        start_req(32'h0000_3004, 2'd2);
        wait_rsp_valid(n);
        tick();
        checks++;
        if (exp_rsp_q.size() != 0) begin
            errors++;
            $display("FAIL after_flush_refill got %0d pending responses required 0", exp_rsp_q.size());
        end
    endtask

    task automatic test_reset_mid_busy();
        data_base          = 32'h0000_7000;
        mem_req_ready_i    = 1'b1;
        refill_rsp_ready_i = 1'b1;
        start_req(32'h0000_4000, 2'd3);
        for (int i = 0; i < 4; i++) tick();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b0 || refill_rsp_valid_o !== 1'b0 || mem_req_addr_o !== '0) begin
            errors++;
            $display("FAIL midreset_valids got mem %0b rsp %0b memaddr %h required 0 0 0",
                     mem_req_valid_o, refill_rsp_valid_o, mem_req_addr_o);
        end
        checks++;
        if (refill_rsp_data_o !== '0 || refill_rsp_addr_o !== '0 || refill_rsp_way_o !== '0 || refill_rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got addr %h way %0d err %0b required 0 0 0",
                     refill_rsp_addr_o, refill_rsp_way_o, refill_rsp_err_o);
        end
        pend_q.delete();
        exp_addr_q.delete();
        exp_rsp_q.delete();
        mem_rsp_valid_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        checks++;
        if (refill_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready got %0b required 1", refill_req_ready_o);
        end
        test_nominal();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_error();
        test_flush_busy();
        test_flush_resp();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
